ssd_scan_driver: RTL
====================

Name: ssd_scan_driver

Overview:
- Display back-end for the ATM controller: consumes the four 7-bit segment patterns (digit4 = left-most) and the 8-bit LED vector the controller produces.
- Time-multiplexes them onto the board's shared 4-digit common-anode seven-segment display.
- Adds frame-synchronous latching so no digit tears mid-frame, per-digit and per-LED blinking (used for the IDLE card prompt and the LOCK/WARNING screens), and 16-level brightness.

Parameters:
- REFRESH_LOG2, 16: log2 of clk cycles per digit slot; must be >= 5. Default gives about 655 us per digit at 100 MHz.
- BLINK_DIV, 25000000: clk cycles per blink half-period; must be >= 2.
- GUARD, 8: cycles at the start of each slot with all anodes off (anti-ghosting); must be < 2**(REFRESH_LOG2-4).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- digit4, digit3, digit2, digit1  in  7 each  segment codes {g,f,e,d,c,b,a}, 1 = segment lit
- led_in  in  8  LED request, bit 7 = left-most
- dig_blink  in  4  per-digit blink enable; bit 3 = digit4
- led_blink  in  8  per-LED blink enable
- bright  in  4  brightness; 15 = full, 0 = 1/16 duty
- AN  out  4  anode selects, active-low; AN[3] = left-most
- SEG  out  7  cathodes {g..a}, active-low
- LED  out  8  board LEDs, active-high
- frame_tick  out  1  one-cycle pulse at each frame start

Behaviour:
- Reset (rst = 0, asynchronous):
  - AN = 4'b1111, SEG = 7'h7F, LED = 0, frame_tick = 0.
  - Scan counter = 0, slot = 3, blink counter = 0, blink_phase = 1 (visible).
  - All shadow registers cleared.
- Scan counter:
  - REFRESH_LOG2 bits, free-running.
  - On wrap, slot advances 3 -> 2 -> 1 -> 0 -> 3.
- Frame start:
  - Defined as the cycle the counter wraps while slot == 0.
  - In that cycle the module copies digit1..4, dig_blink, led_in, led_blink and bright into shadow registers.
  - frame_tick = 1 in the following cycle only.
  - All display and LED outputs derive from the shadows only. Input changes mid-frame are invisible until the next frame.
- Blink:
  - Blink counter counts 0..BLINK_DIV-1. On wrap, blink_phase toggles.
  - While blink_phase = 0, digits with their shadow dig_blink bit set are blanked (anode held off).
  - LEDs with their led_blink bit set are forced to 0 during the same phase. The LED output is registered.
- Slot output, registered with 1-cycle latency from the counter:
  - Let top = the 4 MSBs of the scan counter.
  - The slot's anode is driven low only when all three hold: counter >= GUARD, top <= shadow bright, and the digit is not blink-blanked.
  - Otherwise AN = 4'b1111.
  - SEG = ~shadow pattern of the current slot when the anode is on, else 7'h7F.
- At most one AN bit is low in any cycle. This must hold at every counter value, including the wrap cycle.
- Boundary cases:
  - bright = 15: full slot minus the guard.
  - bright = 0: 1/16 of the slot, minus the guard when the guard overlaps.
  - Blink phase toggle and frame start in the same cycle: both take effect. The new shadow is used with the new phase.
  - Reset mid-frame: outputs blank immediately. After release, the first frame starts once slot 0 completes, so display is blank for about 4 slots. The shadows hold 0, so SEG stays off until the first latch.

Decomposition:
- Shared package (atm_pkg):
  - SEG_OFF = 7'h7F, AN_OFF = 4'hF
  - segment glyph constants used by the ATM screens: C, A, r, d, P, E, -, O, n, F, I, L, S, digits 0-9
- Sub-module blink_gen:
  - Counter plus phase flop, parameter BLINK_DIV, output blink_phase.
  - Reused for the LED[0] idle blink in the controller.

Test Plan (REFRESH_LOG2 = 6, BLINK_DIV = 1000, GUARD = 2):
- Static pattern: digits = 7'h39, 7'h77, 7'h50, 7'h5E ("CArd"), bright = 15, no blink.
  - Required: AN cycles 0111 -> 1011 -> 1101 -> 1110, 64 cycles per slot.
  - Within each slot, AN is off for cycles 0-1 and SEG equals the inverse of the matching code.
  - Never more than one AN bit low.
- Frame latch: change digit4 from 7'h39 to 7'h73 while slot 2 is active.
  - Required: digit4 still shows ~7'h39 until the next frame_tick, then shows ~7'h73.
- Blink: dig_blink = 4'b1000, led_in = 8'h01, led_blink = 8'h01.
  - Required: AN[3] never low and LED[0] = 0 for 1000 cycles, then both active for 1000 cycles, repeating. Other digits are unaffected.
- Brightness: bright = 3.
  - Required: the anode is low only for counter values 2..15 of each 64-cycle slot, i.e. 14 cycles.
- Reset mid-operation: pull rst low in the middle of slot 1.
  - Required: AN = 1111, SEG = 7F and LED = 0 in the same cycle with no clock edge.
  - After release, the first frame_tick occurs 256 cycles later and the display resumes.
- Simultaneous events: align a blink toggle with a frame start.
  - Required: the newly latched digits appear with the new blink phase in the same cycle, with no one-cycle glitch on AN.

Source files
------------

// File: rtl/atm_pkg.sv
// Shared display constants for the ATM controller: blanking values, segment glyphs
// {g,f,e,d,c,b,a} with 1 = lit, and the latched frame record used by the scan driver.
package atm_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;
   localparam logic [3:0] AN_OFF  = 4'hF;

   localparam logic [6:0] GLYPH_C    = 7'h39;
   localparam logic [6:0] GLYPH_A    = 7'h77;
   localparam logic [6:0] GLYPH_R    = 7'h50;
   localparam logic [6:0] GLYPH_D    = 7'h5E;
   localparam logic [6:0] GLYPH_P    = 7'h73;
   localparam logic [6:0] GLYPH_E    = 7'h79;
   localparam logic [6:0] GLYPH_DASH = 7'h40;
   localparam logic [6:0] GLYPH_O    = 7'h3F;
   localparam logic [6:0] GLYPH_N    = 7'h54;
   localparam logic [6:0] GLYPH_F    = 7'h71;
   localparam logic [6:0] GLYPH_I    = 7'h06;
   localparam logic [6:0] GLYPH_L    = 7'h38;
   localparam logic [6:0] GLYPH_S    = 7'h6D;
   localparam logic [6:0] GLYPH_0    = 7'h3F;
   localparam logic [6:0] GLYPH_1    = 7'h06;
   localparam logic [6:0] GLYPH_2    = 7'h5B;
   localparam logic [6:0] GLYPH_3    = 7'h4F;
   localparam logic [6:0] GLYPH_4    = 7'h66;
   localparam logic [6:0] GLYPH_5    = 7'h6D;
   localparam logic [6:0] GLYPH_6    = 7'h7D;
   localparam logic [6:0] GLYPH_7    = 7'h07;
   localparam logic [6:0] GLYPH_8    = 7'h7F;
   localparam logic [6:0] GLYPH_9    = 7'h6F;

   // digits[3] is the left-most digit
   typedef struct packed {
      logic [3:0][6:0] digits;
      logic [3:0]      dig_blink;
      logic [7:0]      led;
      logic [7:0]      led_blink;
      logic [3:0]      bright;
   } shadow_t;

   function automatic logic [3:0] an_sel(input logic [1:0] slot);
      return ~(4'b0001 << slot);
   endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: divides clk by BLINK_DIV and toggles the phase on each wrap.
// Phase resets to 1 so blinking items start out visible.
module blink_gen #(
   parameter int BLINK_DIV = 25000000
) (
   input  logic clk,
   input  logic rst,
   output logic blink_phase
);

   localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count       <= '0;
         blink_phase <= 1'b1;
      end else if (count == LAST) begin
         count       <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode scan driver with frame-synchronous shadow latching,
// per-digit / per-LED blinking and 16-level brightness. Outputs lag the scan counter by one cycle.
module ssd_scan_driver
   import atm_pkg::*;
#(
   parameter int REFRESH_LOG2 = 16,
   parameter int BLINK_DIV    = 25000000,
   parameter int GUARD        = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] digit4,
   input  logic [6:0] digit3,
   input  logic [6:0] digit2,
   input  logic [6:0] digit1,
   input  logic [7:0] led_in,
   input  logic [3:0] dig_blink,
   input  logic [7:0] led_blink,
   input  logic [3:0] bright,
   output logic [3:0] AN,
   output logic [6:0] SEG,
   output logic [7:0] LED,
   output logic       frame_tick
);

   localparam logic [REFRESH_LOG2-1:0] GUARD_CNT = REFRESH_LOG2'(GUARD);

   logic [REFRESH_LOG2-1:0] cnt;
   logic [1:0]              slot;
   shadow_t                 shadow;
   logic                    blink_phase;
   logic                    wrap;
   logic                    frame_start;
   logic [3:0]              top;
   logic [6:0]              pattern;
   logic                    lit;

   blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
      .clk         (clk),
      .rst         (rst),
      .blink_phase (blink_phase)
   );

   assign wrap        = &cnt;
   assign frame_start = wrap && (slot == 2'd0);
   assign top         = cnt[REFRESH_LOG2-1 -: 4];

   // Only the current slot's anode can ever be selected, so at most one AN bit is low.
   always_comb begin
      pattern = shadow.digits[slot];
      lit     = (cnt >= GUARD_CNT) && (top <= shadow.bright)
                && (blink_phase || !shadow.dig_blink[slot]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt        <= '0;
         slot       <= 2'd3;
         shadow     <= '0;
         AN         <= AN_OFF;
         SEG        <= SEG_OFF;
         LED        <= '0;
         frame_tick <= 1'b0;
      end else begin
         cnt <= cnt + 1'b1;
         if (wrap)
            slot <= slot - 2'd1;
         if (frame_start) begin
            shadow.digits    <= {digit4, digit3, digit2, digit1};
            shadow.dig_blink <= dig_blink;
            shadow.led       <= led_in;
            shadow.led_blink <= led_blink;
            shadow.bright    <= bright;
         end
         frame_tick <= frame_start;
         AN         <= lit ? an_sel(slot) : AN_OFF;
         SEG        <= lit ? ~pattern : SEG_OFF;
         LED        <= shadow.led & ~(shadow.led_blink & {8{~blink_phase}});
      end
   end

endmodule
